// File: rtl/scatter_pkg.sv
// Shared definitions for the lane scatter block: default sizing, the
// pointer width, the per-lane occupancy state and the round-robin wrap.
package scatter_pkg;

  localparam int DEF_NUM_LANES  = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int LANE_IDX_W     = $clog2(DEF_NUM_LANES);
  localparam int DEF_SUM_WIDTH  = DEF_DATA_WIDTH + 4;

  // Each lane holds at most one word
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  // Advance a lane index by one, wrapping from the last lane back to lane 0
  function automatic int unsigned next_lane(input int unsigned idx,
                                            input int unsigned num_lanes);
    int unsigned nxt;
    nxt = idx + 1;
    if (nxt >= num_lanes) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scatter_lane_reg.sv
// One-entry output register for a single lane. A load always wins over a
// drain so that a word arriving while the old one leaves keeps the lane full.
// The data register is left untouched on a drain-only cycle.
module scatter_lane_reg
  import scatter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  lane_state_e           r_state;
  lane_state_e           w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;

  // Occupancy state register, cleared asynchronously so in-flight words are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LANE_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy: load keeps/makes the lane full, a drain alone empties it
  always_comb begin
    w_state_nxt = r_state;
    if (i_load) begin
      w_state_nxt = LANE_FULL;
    end else if ((r_state == LANE_FULL) && i_ready) begin
      w_state_nxt = LANE_EMPTY;
    end
  end

  // Data capture on load only; the last word stays visible after a drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == LANE_FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/lane_scatter.sv
// Distributes a single input stream across NUM_LANES one-entry lane
// registers in round-robin order, and tracks the modulo sum and saturating
// count of every accepted word.
// Build option: define LANE_SKIP_EN to let an accept skip over lanes that are
// full and stalled, taking the first free or draining lane after lane_ptr.
// Without it the pointer waits on its lane (strict in-order round robin).
module lane_scatter
  import scatter_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SUM_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic [NUM_LANES-1:0]            out_valid,
  input  logic [NUM_LANES-1:0]            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [$clog2(NUM_LANES)-1:0]    lane_ptr,
  output logic [SUM_WIDTH-1:0]            sent_sum,
  output logic [15:0]                     sent_count
);

  localparam int PTR_W = $clog2(NUM_LANES);

  logic [PTR_W-1:0]     r_ptr;
  logic [SUM_WIDTH-1:0] r_sum;
  logic [15:0]          r_count;

  logic [NUM_LANES-1:0] w_valid;
  logic [NUM_LANES-1:0] w_avail;
  logic [NUM_LANES-1:0] w_load;
  logic [PTR_W-1:0]     w_target;
  logic                 w_found;
  logic                 w_ready;
  logic                 w_accept;

  // A lane can take a word if it is empty or its consumer takes the old one now
  assign w_avail = ~w_valid | out_ready;

`ifdef LANE_SKIP_EN
  logic [PTR_W:0] w_idx;

  // Search from the pointer, with wrap, for the first lane able to take a word
  always_comb begin
    w_target = r_ptr;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W + 1)'(k);
      if (w_idx >= (PTR_W + 1)'(NUM_LANES)) begin
        w_idx = w_idx - (PTR_W + 1)'(NUM_LANES);
      end
      if (!w_found && w_avail[w_idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_target = w_idx[PTR_W-1:0];
      end
    end
  end
`else
  // Strict round robin: only the lane under the pointer may be targeted
  always_comb begin
    w_target = r_ptr;
    w_found  = w_avail[r_ptr];
  end
`endif

  // Ready depends only on registered lane state and out_ready, never on in_valid
  assign w_ready  = rst & w_found;
  assign w_accept = in_valid & w_ready;
  assign in_ready = w_ready;

  // One-hot load strobe for the targeted lane
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_load[i] = w_accept && (w_target == PTR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    scatter_lane_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_data  (in_data),
      .i_ready (out_ready[g]),
      .o_valid (w_valid[g]),
      .o_data  (out_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Pointer moves to the lane after the one just loaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= PTR_W'(next_lane(32'(w_target), NUM_LANES));
    end
  end

  // Running sum of accepted words, wrapping naturally at the accumulator width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + SUM_WIDTH'(in_data);
    end
  end

  // Accepted-word count that sticks at all ones instead of rolling over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_accept && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign out_valid  = w_valid;
  assign lane_ptr   = r_ptr;
  assign sent_sum   = r_sum;
  assign sent_count = r_count;

endmodule

// File: doc/lane_scatter.md
Name: lane_scatter

Overview:
- Stimulus-side counterpart of the N-lane result reduction: takes a single input stream and distributes words round-robin across NUM_LANES independent DUT lanes.
- Each lane has its own one-entry output register with a valid/ready handshake.
- Keeps a running sum of all dispatched words so the bench can cross-check the downstream reduction sum.

Parameters:
NUM_LANES, 10, number of output lanes (≥2)
DATA_WIDTH, 8, width of each data word
SUM_WIDTH, DATA_WIDTH+4, width of the dispatched-sum accumulator (wraps modulo 2^SUM_WIDTH)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept in_data this cycle
in_data  input  DATA_WIDTH  input word
out_valid  output  NUM_LANES  per-lane word held
out_ready  input  NUM_LANES  per-lane consumer accepts
out_data  output  NUM_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
lane_ptr  output  $clog2(NUM_LANES)  lane targeted by the next accept
sent_sum  output  SUM_WIDTH  modulo sum of all accepted words
sent_count  output  16  number of accepted words, saturates at 16'hFFFF

Behaviour:
- Reset (rst low, asynchronous; applies mid-operation too):
  - out_valid = 0, out_data = 0, lane_ptr = 0, sent_sum = 0, sent_count = 0.
  - In-flight lane words are discarded.
  - in_ready is 0 while rst is low.
- Lane register i:
  - full_i = out_valid[i].
  - Drains when out_valid[i] & out_ready[i].
  - Loads when an input accept targets lane i.
  - Load and drain in the same cycle: the new word replaces the old one and out_valid[i] stays 1.
  - A drain with no load clears out_valid[i]; out_data[i] holds its last value.
- in_ready (combinational from registered state and out_ready) = ~out_valid[lane_ptr] | out_ready[lane_ptr]. No combinational path from in_valid to in_ready.
- Accept when in_valid & in_ready. On the next edge:
  - Lane lane_ptr loads in_data and its out_valid becomes 1. Latency is 1 cycle: accepted at edge t, visible on out_data/out_valid after edge t.
  - lane_ptr increments, wrapping NUM_LANES-1 → 0.
  - sent_sum += zero-extended in_data, modulo 2^SUM_WIDTH.
  - sent_count += 1 unless already 16'hFFFF.
- Stall: if lane lane_ptr is full and not draining, in_ready = 0. The pointer holds strictly (in-order round robin); other lanes keep draining independently.
- Empty: in_valid = 0 changes nothing except lane drains.
- No state machine beyond the pointer; each lane is a 2-state EMPTY/FULL register.

Optional Feature:
LANE_SKIP_EN
- Defined:
  - Target lane = first lane, searching lane_ptr, lane_ptr+1, … with wrap, that is empty or draining this cycle.
  - in_ready = 1 if any such lane exists.
  - On accept, lane_ptr = target+1 (wrapped).
  - lane_ptr output still reports the search start.
- Undefined: strict round robin exactly as in Behaviour.

Decomposition:
- Package scatter_pkg holds:
  - default NUM_LANES and DATA_WIDTH;
  - localparam LANE_IDX_W = $clog2(NUM_LANES);
  - localparam SUM_WIDTH;
  - function next_lane(idx) implementing the wrap.
- One sub-module, scatter_lane_reg: a one-entry register with load/drain/valid, instantiated NUM_LANES times via generate.
- Pointer, sum and count logic live in lane_scatter.

Test Plan:
1. Reset then feed 10 words 1..10 with all out_ready=1 → lane i shows value i+1 one cycle after accept; lane_ptr wraps to 0; sent_sum=55; sent_count=10.
2. All out_ready=0, feed 12 words → first 10 accepted; in_ready=0 with lane_ptr=0; sent_count=10. Then raise out_ready[0] only → exactly one more word accepted into lane 0 (same-cycle replace); lane_ptr=1.
3. Feed 20 words of 8'hFF with out_ready=1 → sent_sum=20*255 mod 4096=5100 mod 4096=1004.
4. Assert rst low mid-stream after 5 accepts (asynchronously, between edges) → outputs zero immediately; after release, the next word lands in lane 0 and sent_count=1.
5. Drive in_valid=1 with only lane 3 full and stalled, lane_ptr=3 → in_ready=0 without LANE_SKIP_EN. With LANE_SKIP_EN, the word lands in lane 4 and lane_ptr=5.
6. Drive 65,540 accepts → sent_count saturates at 16'hFFFF while sent_sum continues wrapping.
